// File: rtl/four_bit_register_serial_tx_if.sv
// Serial transmitter bus: load request with parallel word in, serial line
// plus frame status out. The master side requests frames, the slave side
// (the transmitter) serialises them.
interface four_bit_register_serial_tx_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] In;
  logic             Out;
  logic             busy;
  logic             done;

  modport master (
    output load,
    output In,
    input  Out,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  In,
    output Out,
    output busy,
    output done
  );
endinterface

// File: rtl/four_bit_register_serial_tx.sv
// Parallel-to-serial transmitter. A load request captures a WIDTH-bit word
// into a shadow register and sends it LSB-first, framed by a start bit (0)
// and a stop bit (1). Bit timing comes from a clock-enable tick counter, so
// everything stays in the clk domain. All outputs are registered.
module four_bit_register_serial_tx #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 4
) (
  input logic                          clk,
  input logic                          reset,
  four_bit_register_serial_tx_if.slave bus
);

  // Counter widths are kept at least one bit wide so WIDTH=1 still elaborates.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_reg,  state_next;
  logic [WIDTH-1:0]  shadow_reg, shadow_next;
  logic [IDX_W-1:0]  index_reg,  index_next;
  logic [TICK_W-1:0] tick_reg,   tick_next;
  logic              out_reg,    out_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;

  logic              tick_end;
  logic [IDX_W-1:0]  index_inc;
  logic [TICK_W-1:0] tick_inc;

  // Last clk cycle of the current serial bit.
  assign tick_end  = (tick_reg == TICK_LAST);
  assign index_inc = index_reg + 1'b1;
  assign tick_inc  = tick_reg + 1'b1;

  // State and output registers; reset drives the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      index_reg  <= '0;
      tick_reg   <= '0;
      out_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      index_reg  <= index_next;
      tick_reg   <= tick_next;
      out_reg    <= out_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so the registered line changes exactly on the bit boundary edge.
  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    index_next  = index_reg;
    tick_next   = tick_reg;
    out_next    = out_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        out_next  = 1'b1;
        busy_next = 1'b0;
        // The done cycle is spent in IDLE, so a request there is accepted
        // and the next start bit follows straight on.
        if (bus.load) begin
          shadow_next = bus.In;
          state_next  = START;
          tick_next   = '0;
          index_next  = '0;
          out_next    = 1'b0;
          busy_next   = 1'b1;
        end
      end

      START: begin
        tick_next = tick_end ? '0 : tick_inc;
        if (tick_end) begin
          state_next = DATA;
          index_next = '0;
          out_next   = shadow_reg[0];
        end
      end

      DATA: begin
        tick_next = tick_end ? '0 : tick_inc;
        if (tick_end) begin
          if (index_reg == IDX_LAST) begin
            state_next = STOP;
            out_next   = 1'b1;
          end else begin
            index_next = index_inc;
            out_next   = shadow_reg[index_inc];
          end
        end
      end

      STOP: begin
        tick_next = tick_end ? '0 : tick_inc;
        if (tick_end) begin
          state_next = IDLE;
          index_next = '0;
          out_next   = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tick_next  = '0;
        index_next = '0;
        out_next   = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.Out  = out_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_four_bit_register_serial_tx.sv
// Self-checking bench: expected per-cycle {Out,busy,done} values are pushed
// to a queue when a frame is requested and popped/compared each cycle.
module tb_four_bit_register_serial_tx;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  four_bit_register_serial_tx_if #(.WIDTH(4)) bus4 ();
  four_bit_register_serial_tx_if #(.WIDTH(8)) bus8 ();

  four_bit_register_serial_tx #(.WIDTH(4), .TICK_DIV(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  four_bit_register_serial_tx #(.WIDTH(8), .TICK_DIV(2)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  typedef logic [2:0] exp_t;  // {Out, busy, done}

  exp_t q4[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected cycles of one frame plus its done cycle.
  function automatic void push_frame(input bit wide, input logic [7:0] d,
                                     input int w, input int td);
    logic lvl;
    for (int b = 0; b < w + 2; b++) begin
      if (b == 0)      lvl = 1'b0;
      else if (b <= w) lvl = d[b-1];
      else             lvl = 1'b1;
      for (int t = 0; t < td; t++) begin
        if (wide) q8.push_back({lvl, 1'b1, 1'b0});
        else      q4.push_back({lvl, 1'b1, 1'b0});
      end
    end
    if (wide) q8.push_back(3'b101);
    else      q4.push_back(3'b101);
  endfunction

  function automatic void push_idle4(input int n);
    for (int i = 0; i < n; i++) q4.push_back(3'b100);
  endfunction

  task automatic launch4(input logic [3:0] d);
    @(negedge clk);
    bus4.In   = d;
    bus4.load = 1'b1;
    @(posedge clk);
    #1;
    bus4.load = 1'b0;
    push_frame(1'b0, {4'b0000, d}, 4, 4);
  endtask

  task automatic test_reset;
    exp_t o;
    #1 reset = 1'b1;
    #1;
    o = {bus4.Out, bus4.busy, bus4.done};
    n_checks++;
    if (o !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_initial_w4: out/busy/done=%b required 100", o);
    end
    o = {bus8.Out, bus8.busy, bus8.done};
    n_checks++;
    if (o !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_initial_w8: out/busy/done=%b required 100", o);
    end
    @(negedge clk);
    reset = 1'b0;
    // Async reset between clock edges while a frame is running.
    launch4(4'b1110);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    o = {bus4.Out, bus4.busy, bus4.done};
    n_checks++;
    if (o !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_async_midsim: out/busy/done=%b required 100", o);
    end
    q4.delete();
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset: async reset checked");
  endtask

  task automatic test_basic_frame;
    exp_t e, o;
    int   c = 0;
    launch4(4'b1011);
    push_idle4(3);
    while (q4.size() > 0) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_frame cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      c++;
    end
    $display("test_basic_frame: frame 1011 sent");
  endtask

  task automatic test_load_while_busy;
    exp_t e, o;
    int   c = 0;
    launch4(4'b1011);
    bus4.In = 4'b0000;
    push_idle4(6);
    while (q4.size() > 0) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_while_busy cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      if (c == 10) bus4.load = 1'b1;
      if (c == 11) bus4.load = 1'b0;
      c++;
    end
    $display("test_load_while_busy: frame 1011 sent, mid-frame load ignored");
  endtask

  task automatic test_done_cycle_load;
    exp_t e, o;
    int   c = 0;
    bit   requested = 1'b0;
    launch4(4'b1011);
    push_frame(1'b0, 8'h06, 4, 4);
    push_idle4(3);
    while (q4.size() > 0) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL done_cycle_load cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      if (bus4.load) bus4.load = 1'b0;
      if (e[0] && !requested) begin
        requested = 1'b1;
        bus4.In   = 4'b0110;
        bus4.load = 1'b1;
      end
      c++;
    end
    $display("test_done_cycle_load: frames 1011 and 0110 sent back to back");
  endtask

  task automatic test_reset_mid_frame;
    exp_t e, o;
    int   c = 0;
    launch4(4'b1011);
    while (c < 14) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_frame cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      c++;
    end
    #2 reset = 1'b1;
    #1;
    o = {bus4.Out, bus4.busy, bus4.done};
    n_checks++;
    if (o !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid_frame_async: out/busy/done=%b required 100", o);
    end
    q4.delete();
    @(negedge clk);
    reset = 1'b0;
    push_idle4(4);
    c = 0;
    while (q4.size() > 0) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_no_done cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      c++;
    end
    launch4(4'b1001);
    push_idle4(2);
    c = 0;
    while (q4.size() > 0) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_clean_frame cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      c++;
    end
    $display("test_reset_mid_frame: frame abandoned, frame 1001 sent clean");
  endtask

  task automatic test_back_to_back;
    exp_t e, o;
    int   c = 0;
    int   dones = 0;
    @(negedge clk);
    bus4.In   = 4'b0011;
    bus4.load = 1'b1;
    @(posedge clk);
    #1;
    bus4.In = 4'b1100;
    push_frame(1'b0, 8'h03, 4, 4);
    push_frame(1'b0, 8'h0C, 4, 4);
    push_idle4(3);
    while (q4.size() > 0) begin
      @(negedge clk);
      e = q4.pop_front();
      o = {bus4.Out, bus4.busy, bus4.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      if (e[0]) begin
        dones++;
        if (dones == 2) bus4.load = 1'b0;
      end
      c++;
    end
    bus4.load = 1'b0;
    $display("test_back_to_back: frames 0011 and 1100 sent with load held");
  endtask

  task automatic test_wide_frame;
    exp_t e, o;
    int   c = 0;
    @(negedge clk);
    bus8.In   = 8'hA5;
    bus8.load = 1'b1;
    @(posedge clk);
    #1;
    bus8.load = 1'b0;
    bus8.In   = 8'h00;
    push_frame(1'b1, 8'hA5, 8, 2);
    q8.push_back(3'b100);
    q8.push_back(3'b100);
    while (q8.size() > 0) begin
      @(negedge clk);
      e = q8.pop_front();
      o = {bus8.Out, bus8.busy, bus8.done};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wide_frame cycle %0d: out/busy/done=%b required %b", c, o, e);
      end
      c++;
    end
    $display("test_wide_frame: frame A5 sent on 8-bit instance");
  endtask

  initial begin
    bus4.load = 1'b0;
    bus4.In   = '0;
    bus8.load = 1'b0;
    bus8.In   = '0;
    test_reset();
    test_basic_frame();
    test_load_while_busy();
    test_done_cycle_load();
    test_reset_mid_frame();
    test_back_to_back();
    test_wide_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
